// File: rtl/fir_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_seq_ctrl_if
//  Brief    : Sample-strobe / history-RAM / filter-sequencing bundle for the
//             FIR tap sequencer (stats ports present with FIR_SEQ_STATS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_seq_ctrl_if #(
    parameter int AW = 10
);
    logic          smpl_vld;
    logic          wr_en;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          sequencing;
    logic          seq_done;
    logic          primed;
    logic          busy;
    logic          overrun;
`ifdef FIR_SEQ_STATS_EN
    logic [15:0]   drop_cnt;
    logic [15:0]   pass_cnt;

    modport master (
        input  smpl_vld,
        output wr_en, wr_ptr, rd_ptr, sequencing, seq_done,
        output primed, busy, overrun, drop_cnt, pass_cnt
    );
    modport slave (
        output smpl_vld,
        input  wr_en, wr_ptr, rd_ptr, sequencing, seq_done,
        input  primed, busy, overrun, drop_cnt, pass_cnt
    );
`else
    modport master (
        input  smpl_vld,
        output wr_en, wr_ptr, rd_ptr, sequencing, seq_done,
        output primed, busy, overrun
    );
    modport slave (
        output smpl_vld,
        input  wr_en, wr_ptr, rd_ptr, sequencing, seq_done,
        input  primed, busy, overrun
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_seq_ctrl
//  Brief    : Writes each codec sample into the circular history RAM, then
//             walks the read pointer oldest->newest for SEQ_LEN taps and
//             strobes seq_done. Optional macro FIR_SEQ_STATS_EN adds
//             drop_cnt / pass_cnt counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_seq_ctrl #(
    parameter int SEQ_LEN = 1021,
    parameter int DEPTH   = 1024,
    parameter int AW      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_seq_ctrl_if.master         bus
);
    localparam int CW = $clog2(SEQ_LEN + 1);

    localparam logic [CW-1:0] c_seq_len  = CW'(SEQ_LEN);
    localparam logic [CW-1:0] c_last_tap = CW'(SEQ_LEN - 1);
    localparam logic [AW-1:0] c_rd_back  = AW'(SEQ_LEN - 1);

    if ((DEPTH != (1 << AW)) || (DEPTH <= SEQ_LEN)) begin : g_cfg_check
        $error("fir_seq_ctrl: DEPTH must equal 2**AW and exceed SEQ_LEN");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [CW-1:0]   tap_q,     tap_d;
    logic            pend_q,    pend_d;
    logic            overrun_q, overrun_d;
    logic            w_drop;

    // A second sample already waiting while busy has nowhere to go.
    assign w_drop = bus.smpl_vld && (state_q != S_IDLE) && pend_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        tap_d     = tap_q;
        pend_d    = pend_q;
        overrun_d = overrun_q | w_drop;

        if (bus.smpl_vld && !pend_q && (state_q == S_WRITE || state_q == S_RUN)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.smpl_vld) begin
                    state_d = S_WRITE;
                    pend_d  = 1'b0;
                end
            end
            S_WRITE: begin
                cnt_d    = (cnt_q == c_seq_len) ? cnt_q : cnt_q + 1'b1;
                rd_ptr_d = wr_ptr_q - c_rd_back;
                wr_ptr_d = wr_ptr_q + 1'b1;
                tap_d    = '0;
                state_d  = (cnt_q >= c_last_tap) ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (tap_q == c_last_tap) begin
                    state_d = S_DONE;
                end else begin
                    tap_d    = tap_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            S_DONE: begin
                // A waiting sample, or one landing right now, is written next.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_WRITE;
                end else if (bus.smpl_vld) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tap_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tap_q     <= tap_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.wr_en      = (state_q == S_WRITE);
    assign bus.wr_ptr     = wr_ptr_q;
    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.sequencing = (state_q == S_RUN);
    assign bus.seq_done   = (state_q == S_DONE);
    assign bus.primed     = (cnt_q == c_seq_len);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.overrun    = overrun_q;

`ifdef FIR_SEQ_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        pass_cnt_d = pass_cnt_q;
        if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (state_q == S_DONE) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
    assign bus.pass_cnt = pass_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_seq_ctrl
//  Brief    : Random sample strobes against a timeline model of write slots,
//             tap windows and done strobes for fir_seq_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_seq_ctrl;
    localparam int L = 13;
    localparam int D = 16;
    localparam int A = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_seq_ctrl_if #(.AW(A)) bus ();

    fir_seq_ctrl #(.SEQ_LEN(L), .DEPTH(D), .AW(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Timeline model: what each future cycle should show.
    bit exp_wr   [int];
    bit exp_seq  [int];
    int exp_rd   [int];
    bit exp_done [int];
    bit exp_busy [int];
    int busy_end;
    bit end_is_pass;
    bit pend;
    int sched_wp, sched_cnt;
    int cur_wp, cur_cnt;
    bit cur_ovr;
    int drops, passes;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, want);
        end
    endtask

    task automatic model_reset();
        exp_wr.delete(); exp_seq.delete(); exp_rd.delete();
        exp_done.delete(); exp_busy.delete();
        busy_end = -1; end_is_pass = 0; pend = 0;
        sched_wp = 0; sched_cnt = 0; cur_wp = 0; cur_cnt = 0;
        cur_ovr = 0; drops = 0; passes = 0;
    endtask

    task automatic schedule_write(input int w);
        exp_wr[w] = 1;
        if (sched_cnt < L) sched_cnt++;
        if (sched_cnt >= L) begin
            for (int k = 0; k < L; k++) begin
                int x;
                x = sched_wp - L + 1 + k;
                exp_seq[w + 1 + k] = 1;
                exp_rd[w + 1 + k]  = ((x % D) + D) % D;
            end
            exp_done[w + L + 1] = 1;
            busy_end    = w + L + 1;
            end_is_pass = 1;
        end else begin
            busy_end    = w;
            end_is_pass = 0;
        end
        for (int t = w; t <= busy_end; t++) exp_busy[t] = 1;
        sched_wp = (sched_wp + 1) % D;
    endtask

    task automatic check_cycle();
        chk("wr_en",      64'(bus.wr_en),      64'(exp_wr.exists(cyc)));
        chk("wr_ptr",     64'(bus.wr_ptr),     64'(cur_wp));
        chk("sequencing", 64'(bus.sequencing), 64'(exp_seq.exists(cyc)));
        if (exp_seq.exists(cyc)) chk("rd_ptr", 64'(bus.rd_ptr), 64'(exp_rd[cyc]));
        chk("seq_done",   64'(bus.seq_done),   64'(exp_done.exists(cyc)));
        chk("busy",       64'(bus.busy),       64'(exp_busy.exists(cyc)));
        chk("primed",     64'(bus.primed),     64'(cur_cnt >= L));
        chk("overrun",    64'(bus.overrun),    64'(cur_ovr));
`ifdef FIR_SEQ_STATS_EN
        chk("drop_cnt",   64'(bus.drop_cnt),   64'(drops > 65535 ? 65535 : drops));
        chk("pass_cnt",   64'(bus.pass_cnt),   64'(passes % 65536));
`endif
        if (exp_wr.exists(cyc)) begin
            cur_wp = (cur_wp + 1) % D;
            if (cur_cnt < L) cur_cnt++;
        end
        if (exp_done.exists(cyc)) passes++;
    endtask

    task automatic arrive(input bit v);
        bit pass_end_now;
        pass_end_now = (cyc == busy_end) && end_is_pass;
        if (v) begin
            if (cyc > busy_end) begin
                pend = 0;
                schedule_write(cyc + 1);
            end else if (pend) begin
                drops++;
                cur_ovr = 1;
            end else if (pass_end_now) begin
                schedule_write(cyc + 1);
            end else begin
                pend = 1;
            end
        end
        if (pass_end_now && pend) begin
            pend = 0;
            schedule_write(cyc + 1);
        end
    endtask

    task automatic step(input bit v);
        check_cycle();
        arrive(v);
        bus.smpl_vld = v;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic prime();
        for (int i = 0; i < L + 3; i++) begin
            step(1'b1);
            repeat ($urandom_range(2, 6)) step(1'b0);
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        bus.smpl_vld = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        prime();
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 19) == 0);

        // Hold off until a pass is well under way, then reset in the middle of it.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (exp_seq.exists(cyc) && exp_seq.exists(cyc - 5)) begin
                found = 1;
                break;
            end
            step(cyc > busy_end);
        end
        chk("rst_window_found", 64'(found), 64'd1);
        check_cycle();
        rst = 1'b1;
        bus.smpl_vld = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_reset();
        chk("rst_seq_off",  64'(bus.sequencing), 64'd0);
        chk("rst_busy_off", 64'(bus.busy),       64'd0);

        prime();
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) == 0);
        for (int i = 0; i < 2 * L + 10; i++) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end
endmodule
`default_nettype wire
